// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Owns the fetch PC and issues in-order requests to instruction memory. Returned
// words are buffered with their PC and offered to decode over valid/ready.
// A redirect flushes the buffer and restarts fetch at the new PC. Responses that
// are still in flight at that point are discarded when they arrive.
// Optional build macro FETCH_PERF_CNT_EN adds two saturating performance counters,
// perf_fetched_o and perf_stall_o.
module fetch_unit #(
   parameter int                AWIDTH    = 32,
   parameter int                DWIDTH    = 32,
   parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h0100_0000),
   parameter int                DEPTH     = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_o,
   output logic [AWIDTH-1:0] imem_addr_o,
   input  logic              imem_rsp_valid_i,
   input  logic [DWIDTH-1:0] imem_rsp_data_i,
   input  logic              redirect_i,
   input  logic [AWIDTH-1:0] redirect_pc_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [AWIDTH-1:0] pc_o,
   output logic [DWIDTH-1:0] insn_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetched_o,
   output logic [31:0]       perf_stall_o
`endif
);

   // Pointer width indexes the buffer. Occupancy-style counters need one extra
   // bit so that the value DEPTH itself can be represented.
   localparam int                PW        = $clog2(DEPTH);
   localparam int                CW        = PW + 1;
   localparam logic [CW:0]       DEPTH_LIM = (CW + 1)'(DEPTH);
   localparam logic [AWIDTH-1:0] PC_STEP   = AWIDTH'(4);

   // Architectural state
   logic [AWIDTH-1:0] fetch_pc_reg, fetch_pc_next;
   logic [AWIDTH-1:0] rsp_pc_reg, rsp_pc_next;
   logic [CW-1:0]     count_reg, count_next;
   logic [CW-1:0]     inflight_reg, inflight_next;
   logic [CW-1:0]     drop_cnt_reg, drop_cnt_next;
   logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;

   // Buffer storage: PC and instruction of each entry
   logic [AWIDTH-1:0] pc_mem   [DEPTH];
   logic [DWIDTH-1:0] insn_mem [DEPTH];

   // Per-cycle events
   logic [CW:0]       credit_sum;
   logic              issue;
   logic              push;
   logic              drop;
   logic              pop;
   logic [AWIDTH-1:0] redirect_pc_aligned;

   // The low two bits of the redirect target are ignored: PCs are word aligned.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs      = ^redirect_pc_i[1:0];
   assign redirect_pc_aligned = {redirect_pc_i[AWIDTH-1:2], 2'b00};

   // Event decode. Every request in flight owns a buffer slot, so a request is
   // only issued while occupancy plus outstanding requests leave room. The
   // reset term keeps the request low while rst is held.
   always_comb begin
      credit_sum = {1'b0, count_reg} + {1'b0, inflight_reg};
      issue      = !rst && !redirect_i && (credit_sum < DEPTH_LIM);
      push       = imem_rsp_valid_i && (drop_cnt_reg == '0) && !redirect_i;
      drop       = imem_rsp_valid_i && (drop_cnt_reg != '0);
      pop        = valid_o && ready_i;
   end

   // Next-state computation for PCs, counters and buffer pointers
   always_comb begin
      fetch_pc_next = fetch_pc_reg;
      rsp_pc_next   = rsp_pc_reg;
      count_next    = count_reg;
      inflight_next = inflight_reg;
      drop_cnt_next = drop_cnt_reg;
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;

      // Outstanding requests track issue and response independently of
      // redirects: dropped responses still retire their request.
      case ({issue, imem_rsp_valid_i})
         2'b10:   inflight_next = inflight_reg + CW'(1);
         2'b01:   inflight_next = inflight_reg - CW'(1);
         default: inflight_next = inflight_reg;
      endcase

      if (redirect_i) begin
         // Everything still outstanding after this cycle belongs to the old
         // path. Recomputing from inflight each time makes back-to-back
         // redirects count each response exactly once.
         fetch_pc_next = redirect_pc_aligned;
         rsp_pc_next   = redirect_pc_aligned;
         count_next    = '0;
         wr_ptr_next   = '0;
         rd_ptr_next   = '0;
         drop_cnt_next = inflight_reg - CW'(imem_rsp_valid_i);
      end else begin
         if (issue) begin
            fetch_pc_next = fetch_pc_reg + PC_STEP;
         end
         if (push) begin
            rsp_pc_next = rsp_pc_reg + PC_STEP;
            wr_ptr_next = wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
         end
         if (drop) begin
            drop_cnt_next = drop_cnt_reg - CW'(1);
         end
         case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   // State register with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_reg <= BASE_ADDR;
         rsp_pc_reg   <= BASE_ADDR;
         count_reg    <= '0;
         inflight_reg <= '0;
         drop_cnt_reg <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
      end else begin
         fetch_pc_reg <= fetch_pc_next;
         rsp_pc_reg   <= rsp_pc_next;
         count_reg    <= count_next;
         inflight_reg <= inflight_next;
         drop_cnt_reg <= drop_cnt_next;
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
      end
   end

   // Buffer write: a kept response is stored with the PC it was fetched from.
   // Contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_reg]   <= rsp_pc_reg;
         insn_mem[wr_ptr_reg] <= imem_rsp_data_i;
      end
   end

   // Outputs. valid_o comes straight from occupancy, and the head fields read as
   // zero whenever it is low, so reset clears all of them at once.
   always_comb begin
      imem_req_o  = issue;
      imem_addr_o = fetch_pc_reg;
      valid_o     = (count_reg != '0);
      pc_o        = valid_o ? pc_mem[rd_ptr_reg]   : '0;
      insn_o      = valid_o ? insn_mem[rd_ptr_reg] : '0;
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_reg;
   logic [31:0] perf_stall_reg;

   // Saturating counters: transfers to decode, and idle cycles not caused by a
   // redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched_reg <= '0;
         perf_stall_reg   <= '0;
      end else begin
         if (pop && (perf_fetched_reg != 32'hFFFF_FFFF)) begin
            perf_fetched_reg <= perf_fetched_reg + 32'd1;
         end
         if (!valid_o && !redirect_i && (perf_stall_reg != 32'hFFFF_FFFF)) begin
            perf_stall_reg <= perf_stall_reg + 32'd1;
         end
      end
   end

   assign perf_fetched_o = perf_fetched_reg;
   assign perf_stall_o   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an in-order memory model of
// configurable latency and a head monitor that tracks the expected PC sequence.
module tb_fetch_unit;

   localparam logic [31:0] BASE = 32'h0100_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] pc_o;
   logic [31:0] insn_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_o;
   logic [31:0] perf_stall_o;
`endif

   fetch_unit dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req_o       (imem_req_o),
      .imem_addr_o      (imem_addr_o),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i),
      .valid_o          (valid_o),
      .ready_i          (ready_i),
      .pc_o             (pc_o),
      .insn_o           (insn_o)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched_o   (perf_fetched_o),
      .perf_stall_o     (perf_stall_o)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory contents: a fixed scramble of the address
   function automatic logic [31:0] insn_of(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'hC0DE_0001;
   endfunction

   // ---------------- memory model ----------------
   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t mem_q[$];
   int   cyc      = 0;
   int   lat_min  = 1;
   int   lat_max  = 1;
   int   last_due = 0;

   initial begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = insn_of(mem_q[0].addr);
            void'(mem_q.pop_front());
         end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
         end
         @(negedge clk);
         if (rst) begin
            mem_q.delete();
            last_due = 0;
         end else if (imem_req_o) begin
            int   d;
            req_t r;
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            r.addr = imem_addr_o;
            r.due  = d;
            mem_q.push_back(r);
         end
      end
   end

   // ---------------- head monitor ----------------
   logic [31:0] pc_load_val = BASE;
   int          pc_load_seq = 0;
   int          n_xfer      = 0;

   initial begin
      logic [31:0] exp_pc;
      int          seen_seq;
      bit          prev_hold;
      exp_pc    = BASE;
      seen_seq  = 0;
      prev_hold = 1'b0;
      forever begin
         @(negedge clk);
         if (seen_seq != pc_load_seq) begin
            exp_pc   = pc_load_val;
            seen_seq = pc_load_seq;
         end
         if (rst) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) check_value("hold_valid", valid_o, 1);
            if (valid_o) begin
               check_value("head_pc", pc_o, exp_pc);
               check_value("head_insn", insn_o, insn_of(exp_pc));
               if (ready_i) begin
                  $display("xfer pc=%h insn=%h", pc_o, insn_o);
                  n_xfer++;
                  exp_pc = exp_pc + 32'd4;
               end
            end else begin
               check_value("idle_zero", {pc_o, insn_o}, 64'h0);
            end
            prev_hold = valid_o && !ready_i && !redirect_i;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect_i    = 1'b1;
      redirect_pc_i = pc;
      @(negedge clk);
      check_value("redir_noreq", imem_req_o, 0);
      #1;
      pc_load_val = {pc[31:2], 2'b00};
      pc_load_seq++;
      @(posedge clk);
      #2;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
   endtask

   task automatic wait_req(input string tag, input logic [31:0] exp_addr);
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (imem_req_o) begin
            seen = 1'b1;
            break;
         end
      end
      if (seen) check_value(tag, imem_addr_o, exp_addr);
      else      check_value({tag, "_timeout"}, 0, 1);
   endtask

   task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (valid_o) begin
            seen = 1'b1;
            break;
         end
      end
      if (seen) begin
         check_value(tag, pc_o, exp_pc);
         check_value({tag, "_insn"}, insn_o, insn_of(exp_pc));
      end else begin
         check_value({tag, "_timeout"}, 0, 1);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int xfer_mark;
      rst           = 1'b1;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      ready_i       = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_value("rst_req", imem_req_o, 0);
      check_value("rst_valid", valid_o, 0);
      check_value("rst_pc", pc_o, 0);
      check_value("rst_insn", insn_o, 0);
`ifdef FETCH_PERF_CNT_EN
      check_value("rst_perf_fetched", perf_fetched_o, 0);
      check_value("rst_perf_stall", perf_stall_o, 0);
`endif

      // Reset release with 1-cycle memory and decode always ready
      @(posedge clk);
      #2;
      rst     = 1'b0;
      ready_i = 1'b1;
      @(negedge clk);
      check_value("first_req", imem_req_o, 1);
      check_value("first_addr", imem_addr_o, BASE);
      check_value("first_valid", valid_o, 0);
      @(negedge clk);
      check_value("second_req", imem_req_o, 1);
      check_value("second_addr", imem_addr_o, BASE + 32'd4);
      check_value("second_valid", valid_o, 0);
      @(negedge clk);
      check_value("lat2_valid", valid_o, 1);
      check_value("lat2_pc", pc_o, BASE);
      check_value("lat2_insn", insn_o, insn_of(BASE));
      check_value("lat2_credit_full", imem_req_o, 0);
      repeat (10) next_cycle();

      // Decode stalls for 5 cycles
      next_cycle();
      ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            check_value("stall_noreq", imem_req_o, 0);
            check_value("stall_valid", valid_o, 1);
         end
      end
      next_cycle();
      ready_i = 1'b1;
      repeat (10) next_cycle();

      // Redirect with two responses in flight (3-cycle memory)
      ready_i = 1'b0;
      repeat (6) next_cycle();
      lat_min = 3;
      lat_max = 3;
      do_redirect(32'h0100_0200);
      @(negedge clk);
      check_value("r1_req_a", imem_addr_o, 32'h0100_0200);
      next_cycle();
      @(negedge clk);
      check_value("r1_req_b", imem_addr_o, 32'h0100_0204);
      next_cycle();
      do_redirect(32'h0100_0103);
      wait_req("r1_new_addr", 32'h0100_0100);
      wait_valid("r1_new_pc", 32'h0100_0100);
      next_cycle();
      lat_min = 1;
      lat_max = 1;
      ready_i = 1'b1;
      repeat (8) next_cycle();

      // Redirect coinciding with a transfer and a response
      ready_i = 1'b0;
      repeat (8) next_cycle();
      ready_i = 1'b1;
      do_redirect(32'h0100_0400);
      next_cycle();
      next_cycle();
      xfer_mark = n_xfer;
      do_redirect(32'h0100_0800);
      check_value("r2_xfer_done", n_xfer - xfer_mark, 1);
      @(negedge clk);
      check_value("r2_valid_next", valid_o, 0);
      wait_valid("r2_new_pc", 32'h0100_0800);
      repeat (4) next_cycle();

      // Random latency 1-4 and random ready
      lat_min   = 1;
      lat_max   = 4;
      xfer_mark = n_xfer;
      for (int i = 0; i < 300; i++) begin
         next_cycle();
         ready_i = ($urandom_range(1, 0) == 1);
      end
      check_value("rand_progress", (n_xfer - xfer_mark) >= 30, 1);
      ready_i = 1'b1;
      repeat (6) next_cycle();

      // Reset in the middle of streaming
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_value("midrst_req", imem_req_o, 0);
      check_value("midrst_valid", valid_o, 0);
      check_value("midrst_pc", pc_o, 0);
      check_value("midrst_insn", insn_o, 0);
`ifdef FETCH_PERF_CNT_EN
      check_value("midrst_perf_fetched", perf_fetched_o, 0);
      check_value("midrst_perf_stall", perf_stall_o, 0);
`endif
      pc_load_val = BASE;
      pc_load_seq++;
      lat_min = 1;
      lat_max = 1;
      @(posedge clk);
      #2;
      rst       = 1'b0;
      xfer_mark = n_xfer;
      wait_req("midrst_restart_addr", BASE);
      wait_valid("midrst_restart_pc", BASE);
      repeat (8) next_cycle();
      ready_i = 1'b0;
      repeat (3) next_cycle();
`ifdef FETCH_PERF_CNT_EN
      @(negedge clk);
      #1;
      check_value("perf_fetched_total", perf_fetched_o, n_xfer - xfer_mark);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Global bound on run time
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule
